// File: rtl/bank_rotate_ctrl_pkg.sv
// mha_pkg: shared types and constants for the bank rotation controller.
//   rd_state_t : read-side FSM states (idle, active sweep, one-cycle release)
//   STATS_W    : width of the optional stall counters
//   ptr_w()    : bit width of a modulo-N pointer (at least 1 bit)
package mha_pkg;

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_ACTIVE  = 2'd1,
        RD_RELEASE = 2'd2
    } rd_state_t;

    localparam int STATS_W = 32;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bank_rotate_ctrl_if.sv
// bank_rotate_ctrl_if: producer/consumer handshake plus RAM port controls.
//   in_valid / in_ready      : producer write handshake
//   ena / addra              : one-hot port-A bank enable and shared address
//   out_ready                : consumer accepts a read issue
//   enb / addrb              : one-hot port-B bank enable and shared address
//   rd_data_valid / rd_last  : RAM output qualifier and end-of-bank marker
//   bank_full                : per-bank "holds unreleased data" flags
// master = producer/consumer side, slave = the controller.
interface bank_rotate_ctrl_if #(
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_WIDTH = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [NUM_BANKS-1:0]  ena;
    logic [ADDR_WIDTH-1:0] addra;
    logic                  out_ready;
    logic [NUM_BANKS-1:0]  enb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic                  rd_data_valid;
    logic                  rd_last;
    logic [NUM_BANKS-1:0]  bank_full;

    modport master (
        output in_valid, out_ready,
        input  in_ready, ena, addra, enb, addrb, rd_data_valid, rd_last, bank_full
    );

    modport slave (
        input  in_valid, out_ready,
        output in_ready, ena, addra, enb, addrb, rd_data_valid, rd_last, bank_full
    );
endinterface

// File: rtl/bank_rotate_ptr.sv
// bank_rotate_ptr: modulo-N bank pointer.
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   adv      : advance by one, wrapping N-1 -> 0
//   ptr      : current pointer value
module bank_rotate_ptr
    import mha_pkg::*;
#(
    parameter  int N = 2,
    localparam int W = ptr_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (adv) ptr_d = (ptr_q == W'(N - 1)) ? '0 : ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/bank_rotate_ctrl.sv
// bank_rotate_ctrl: ping-pong (N-way) controller for a set of dual-port RAM
// banks. The producer fills banks in rotation through port A; each full bank
// is swept READ_PASSES times through port B and then released for refill.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : bank_rotate_ctrl_if.slave (handshakes, RAM enables/addresses,
//               rd_data_valid/rd_last, bank_full)
//   wr_stall_cnt, rd_stall_cnt : saturating stall counters, present only when
//               BANK_ROTATE_CTRL_STATS_EN is defined
module bank_rotate_ctrl
    import mha_pkg::*;
#(
    parameter int NUM_BANKS   = 2,
    parameter int DEPTH       = 64,
    parameter int ADDR_WIDTH  = 6,
    parameter int READ_PASSES = 1,
    parameter int RD_LATENCY  = 1
) (
    input  logic clk,
    input  logic rst,
    bank_rotate_ctrl_if.slave bus
`ifdef BANK_ROTATE_CTRL_STATS_EN
    ,
    output logic [STATS_W-1:0] wr_stall_cnt,
    output logic [STATS_W-1:0] rd_stall_cnt
`endif
);

    localparam int                    PW        = ptr_w(NUM_BANKS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [3:0]            LAST_PASS = 4'(READ_PASSES - 1);

    logic [PW-1:0]         wb, rb;
    logic                  wb_adv, rb_adv;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d, ra_q, ra_d;
    logic [3:0]            pass_q, pass_d;
    rd_state_t             rd_state_q, rd_state_d;
    logic [NUM_BANKS-1:0]  bank_full_q, bank_full_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d, last_q, last_d;
    logic                  wr_fire, rd_issue, rd_final;

    bank_rotate_ptr #(.N(NUM_BANKS)) u_wb_ptr (.clk(clk), .rst(rst), .adv(wb_adv), .ptr(wb));
    bank_rotate_ptr #(.N(NUM_BANKS)) u_rb_ptr (.clk(clk), .rst(rst), .adv(rb_adv), .ptr(rb));

    always_comb begin
        // Gating with rst keeps every strobe low while reset is held.
        wr_fire  = bus.in_valid && !rst && !bank_full_q[wb];
        rd_issue = (rd_state_q == RD_ACTIVE) && bus.out_ready && !rst;
        rd_final = rd_issue && (ra_q == LAST_ADDR) && (pass_q == LAST_PASS);

        wa_d        = wa_q;
        wb_adv      = 1'b0;
        bank_full_d = bank_full_q;
        if (wr_fire) begin
            if (wa_q == LAST_ADDR) begin
                wa_d            = '0;
                wb_adv          = 1'b1;
                bank_full_d[wb] = 1'b1;
            end else begin
                wa_d = wa_q + 1'b1;
            end
        end

        // The write side only touches empty banks and the read side only
        // releases a full one, so the two bank_full updates never collide.
        ra_d       = ra_q;
        pass_d     = pass_q;
        rd_state_d = rd_state_q;
        rb_adv     = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (bank_full_q[rb]) rd_state_d = RD_ACTIVE;
            end
            RD_ACTIVE: begin
                if (rd_issue) begin
                    if (ra_q == LAST_ADDR) begin
                        ra_d = '0;
                        if (pass_q == LAST_PASS) rd_state_d = RD_RELEASE;
                        else                     pass_d     = pass_q + 1'b1;
                    end else begin
                        ra_d = ra_q + 1'b1;
                    end
                end
            end
            RD_RELEASE: begin
                bank_full_d[rb] = 1'b0;
                rb_adv          = 1'b1;
                pass_d          = '0;
                rd_state_d      = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase

        // Issue strobe delayed to line up with RAM output data.
        vld_d     = '0;
        last_d    = '0;
        vld_d[0]  = rd_issue;
        last_d[0] = rd_final;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wa_q        <= '0;
            ra_q        <= '0;
            pass_q      <= '0;
            rd_state_q  <= RD_IDLE;
            bank_full_q <= '0;
            vld_q       <= '0;
            last_q      <= '0;
        end else begin
            wa_q        <= wa_d;
            ra_q        <= ra_d;
            pass_q      <= pass_d;
            rd_state_q  <= rd_state_d;
            bank_full_q <= bank_full_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
        end
    end

    assign bus.in_ready      = !rst && !bank_full_q[wb];
    assign bus.ena           = wr_fire  ? (NUM_BANKS'(1) << wb) : '0;
    assign bus.addra         = rst ? '0 : wa_q;
    assign bus.enb           = rd_issue ? (NUM_BANKS'(1) << rb) : '0;
    assign bus.addrb         = rst ? '0 : ra_q;
    assign bus.rd_data_valid = !rst && vld_q[RD_LATENCY-1];
    assign bus.rd_last       = !rst && last_q[RD_LATENCY-1];
    assign bus.bank_full     = bank_full_q;

`ifdef BANK_ROTATE_CTRL_STATS_EN
    logic [STATS_W-1:0] wr_stall_q, wr_stall_d, rd_stall_q, rd_stall_d;

    always_comb begin
        wr_stall_d = wr_stall_q;
        rd_stall_d = rd_stall_q;
        if (bus.in_valid && !bus.in_ready && (wr_stall_q != '1))
            wr_stall_d = wr_stall_q + 1'b1;
        if ((rd_state_q == RD_ACTIVE) && !bus.out_ready && (rd_stall_q != '1))
            rd_stall_d = rd_stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_stall_q <= '0;
            rd_stall_q <= '0;
        end else begin
            wr_stall_q <= wr_stall_d;
            rd_stall_q <= rd_stall_d;
        end
    end

    assign wr_stall_cnt = wr_stall_q;
    assign rd_stall_cnt = rd_stall_q;
`endif

endmodule

// File: tb/tb_bank_rotate_ctrl.sv
// Testbench for bank_rotate_ctrl with NUM_BANKS=3, DEPTH=4, READ_PASSES=2,
// RD_LATENCY=2: a directed vector table, hand-written multi-cycle sequences
// and a randomized run against a count-based reference model.
module tb_bank_rotate_ctrl;

    localparam int NB  = 3;
    localparam int DP  = 4;
    localparam int AW  = 2;
    localparam int RP  = 2;
    localparam int LAT = 2;
    localparam int P   = DP * RP;   // issues per bank

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bank_rotate_ctrl_if #(.NUM_BANKS(NB), .ADDR_WIDTH(AW)) bus ();

`ifdef BANK_ROTATE_CTRL_STATS_EN
    logic [31:0] wr_stall_cnt, rd_stall_cnt;
`endif

    bank_rotate_ctrl #(
        .NUM_BANKS(NB), .DEPTH(DP), .ADDR_WIDTH(AW),
        .READ_PASSES(RP), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef BANK_ROTATE_CTRL_STATS_EN
        ,
        .wr_stall_cnt(wr_stall_cnt),
        .rd_stall_cnt(rd_stall_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst, iv, ordy;
        logic       ir;
        logic [2:0] ena;
        logic [1:0] addra;
        logic [2:0] enb;
        logic [1:0] addrb;
        logic [2:0] bf;
        logic       rdv, last;
    } vec_t;

    vec_t tbl [12];

    // ---------------- reference model ----------------
    // Everything derives from three totals since reset: words written (mW),
    // read issues (mI) and banks released (mR). Banks k in [mR, mW/DP) are
    // full, bank k lives at index k % NB.
    int mW, mI, mR;
    bit mAct, mRel;
    bit mv [LAT];
    bit ml [LAT];

    task automatic model_reset();
        mW = 0; mI = 0; mR = 0; mAct = 0; mRel = 0;
        for (int i = 0; i < LAT; i++) begin mv[i] = 0; ml[i] = 0; end
    endtask

    task automatic model_cycle();
        int F;
        logic [2:0] bf;
        bit ir, wfire, issue, fin;
        F  = mW / DP;
        bf = '0;
        for (int k = mR; k < F; k++) bf[k % NB] = 1'b1;
        chk("rand_bank_full", bus.bank_full, bf);
        if (rst) begin
            chk("rand_rst_in_ready", bus.in_ready, 0);
            chk("rand_rst_ena", bus.ena, 0);
            chk("rand_rst_enb", bus.enb, 0);
            chk("rand_rst_rdv", bus.rd_data_valid, 0);
            chk("rand_rst_last", bus.rd_last, 0);
            model_reset();
            return;
        end
        ir    = (F - mR) < NB;
        wfire = bus.in_valid && ir;
        issue = mAct && bus.out_ready;
        fin   = issue && ((mI - mR * P) == P - 1);
        chk("rand_in_ready", bus.in_ready, ir);
        chk("rand_ena", bus.ena, wfire ? (1 << (F % NB)) : 0);
        if (wfire) chk("rand_addra", bus.addra, mW % DP);
        chk("rand_enb", bus.enb, issue ? (1 << (mR % NB)) : 0);
        if (issue) chk("rand_addrb", bus.addrb, mI % DP);
        chk("rand_rdv", bus.rd_data_valid, mv[LAT-1]);
        chk("rand_last", bus.rd_last, ml[LAT-1]);
        for (int i = LAT - 1; i > 0; i--) begin mv[i] = mv[i-1]; ml[i] = ml[i-1]; end
        mv[0] = issue;
        ml[0] = fin;
        if (wfire) mW++;
        if (mRel) begin
            mR++; mRel = 0;
        end else if (!mAct) begin
            if (F > mR) mAct = 1;
        end else if (issue) begin
            mI++;
            if (fin) begin mAct = 0; mRel = 1; end
        end
    endtask

    initial begin
        int ni, lc, vc, nvalid, orp, cyc;
        bit seen, done;

        // rst, iv, or | ir, ena, addra, enb, addrb, bf, rdv, last
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 2'd0, 3'b000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 2'd0, 3'b000, 2'd0, 3'b000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 2'd1, 3'b000, 2'd0, 3'b000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 2'd2, 3'b000, 2'd0, 3'b000, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 2'd3, 3'b000, 2'd0, 3'b000, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'd0, 3'b000, 2'd0, 3'b001, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'd0, 3'b000, 2'd0, 3'b001, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 2'd0, 3'b001, 2'd0, 3'b001, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'd0, 3'b000, 2'd0, 3'b001, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 2'd0, 3'b001, 2'd1, 3'b001, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'd0, 3'b000, 2'd0, 3'b001, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 2'd0, 3'b001, 2'd2, 3'b001, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst; bus.in_valid = tbl[i].iv; bus.out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].ir);
            chk($sformatf("tbl%0d_ena", i), bus.ena, tbl[i].ena);
            if (tbl[i].ena != 0) chk($sformatf("tbl%0d_addra", i), bus.addra, tbl[i].addra);
            chk($sformatf("tbl%0d_enb", i), bus.enb, tbl[i].enb);
            if (tbl[i].enb != 0) chk($sformatf("tbl%0d_addrb", i), bus.addrb, tbl[i].addrb);
            chk($sformatf("tbl%0d_bank_full", i), bus.bank_full, tbl[i].bf);
            chk($sformatf("tbl%0d_rdv", i), bus.rd_data_valid, tbl[i].rdv);
            chk($sformatf("tbl%0d_last", i), bus.rd_last, tbl[i].last);
            next_cycle();
        end

        // ---- fill all banks, then drain bank0 with the writer waiting ----
        do_reset();
        bus.in_valid = 1'b1;
        for (int b = 0; b < 12; b++) begin
            @(negedge clk);
            chk("A_fill_in_ready", bus.in_ready, 1);
            chk("A_fill_ena", bus.ena, 1 << (b / DP));
            chk("A_fill_addra", bus.addra, b % DP);
            next_cycle();
        end
        @(negedge clk);
        chk("A_full_bank_full", bus.bank_full, 3'b111);
        chk("A_beat13_in_ready", bus.in_ready, 0);
        chk("A_beat13_ena", bus.ena, 0);
        next_cycle();
        bus.out_ready = 1'b1;
        ni = 0; lc = -1; vc = -1; nvalid = 0; done = 0;
        for (cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (lc < 0 && bus.enb != 0) begin
                chk("A_enb", bus.enb, 3'b001);
                chk("A_addrb", bus.addrb, ni % DP);
                ni++;
                if (ni == P) lc = cyc;
            end
            if (bus.rd_data_valid) begin
                nvalid++;
                chk("A_rd_last", bus.rd_last, nvalid == P);
                if (nvalid == P) vc = cyc;
            end
            if (lc >= 0 && cyc == lc + 1) begin
                chk("A_release_in_ready", bus.in_ready, 0);
                chk("A_release_enb", bus.enb, 0);
            end
            if (lc >= 0 && cyc == lc + 2) begin
                chk("A_after_release_in_ready", bus.in_ready, 1);
                chk("A_after_release_ena", bus.ena, 3'b001);
                chk("A_after_release_addra", bus.addra, 0);
                chk("A_after_release_bank_full", bus.bank_full, 3'b110);
                chk("A_last_valid_cycle", vc, lc + LAT);
                done = 1;
            end
            if (!done) next_cycle();
        end
        if (!done) chk("A_timeout", 0, 1);
        next_cycle();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;

        // ---- reset in the middle of a read sweep ----
        do_reset();
        bus.in_valid = 1'b1;
        for (int b = 0; b < DP; b++) begin
            @(negedge clk);
            chk("B_fill_addra", bus.addra, b);
            next_cycle();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        ni = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.enb != 0) ni++;
            if (ni == 3) done = 1;
            next_cycle();
        end
        if (!done) chk("B_timeout", 0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("B_rst_in_ready", bus.in_ready, 0);
        chk("B_rst_ena", bus.ena, 0);
        chk("B_rst_enb", bus.enb, 0);
        chk("B_rst_addrb", bus.addrb, 0);
        chk("B_rst_rdv", bus.rd_data_valid, 0);
        next_cycle();
        rst = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        chk("B_post_bank_full", bus.bank_full, 0);
        chk("B_post_rdv", bus.rd_data_valid, 0);
        chk("B_post_last", bus.rd_last, 0);
        chk("B_post_in_ready", bus.in_ready, 1);
        next_cycle();
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen |= bus.rd_data_valid | (bus.enb != 0);
            next_cycle();
        end
        chk("B_no_ghost_reads", seen, 0);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        for (int b = 0; b < DP; b++) begin
            @(negedge clk);
            chk("B_refill_ena", bus.ena, 3'b001);
            chk("B_refill_addra", bus.addra, b);
            next_cycle();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("B_refill_bank_full", bus.bank_full, 3'b001);
        next_cycle();

        // ---- randomized run against the model ----
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            case (c / 400)
                0:       orp = 20;
                1:       orp = 50;
                2:       orp = 90;
                3:       orp = 10;
                default: orp = 70;
            endcase
            rst           = ($urandom_range(0, 299) == 0);
            bus.in_valid  = ($urandom_range(0, 99) < 80);
            bus.out_ready = ($urandom_range(0, 99) < orp);
            @(negedge clk);
            model_cycle();
            next_cycle();
        end
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
